// File: rtl/rel_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rel_cmp_pkg
// Purpose : Relation codes, FSM encoding and flag positions for rel_cmp_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package rel_cmp_pkg;

    localparam logic [2:0] REL_EQ   = 3'd0;
    localparam logic [2:0] REL_NEQ  = 3'd1;
    localparam logic [2:0] REL_CEQ  = 3'd2;
    localparam logic [2:0] REL_CNEQ = 3'd3;
    localparam logic [2:0] REL_LT   = 3'd4;
    localparam logic [2:0] REL_GT   = 3'd5;
    localparam logic [2:0] REL_LTE  = 3'd6;
    localparam logic [2:0] REL_GTE  = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CAP  = 2'd1;
    localparam logic [1:0] ST_CMP  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CAP  = ST_CAP,
        S_CMP  = ST_CMP,
        S_RESP = ST_RESP
    } state_e;

    localparam int N_FLAGS  = 8;
    localparam int FLG_EQ   = 0;
    localparam int FLG_NEQ  = 1;
    localparam int FLG_CEQ  = 2;
    localparam int FLG_CNEQ = 3;
    localparam int FLG_LT   = 4;
    localparam int FLG_GT   = 5;
    localparam int FLG_LTE  = 6;
    localparam int FLG_GTE  = 7;

    function automatic logic rel_select(input logic [N_FLAGS-1:0] flags,
                                        input logic [2:0]         op);
        logic res;
        res = 1'b0;
        case (op)
            REL_EQ:   res = flags[FLG_EQ];
            REL_NEQ:  res = flags[FLG_NEQ];
            REL_CEQ:  res = flags[FLG_CEQ];
            REL_CNEQ: res = flags[FLG_CNEQ];
            REL_LT:   res = flags[FLG_LT];
            REL_GT:   res = flags[FLG_GT];
            REL_LTE:  res = flags[FLG_LTE];
            REL_GTE:  res = flags[FLG_GTE];
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rel_cmp_unit.sv
`default_nettype none
// ============================================================================
// Module  : rel_cmp_unit
// Purpose : Combinational evaluation of all eight relations on one operand pair.
// Revision: 1.0 - initial release
// ============================================================================
module rel_cmp_unit
    import rel_cmp_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [N_FLAGS-1:0] flags_o
);

    logic eq;
    logic lt;

    assign eq = (a_i == b_i);

    generate
        if (SIGNED) begin : g_signed
            assign lt = ($signed(a_i) < $signed(b_i));
        end else begin : g_unsigned
            assign lt = (a_i < b_i);
        end
    endgenerate

    // ceq/cneq only differ from eq/neq for x/z operands, which never reach silicon.
    always_comb begin
        flags_o           = '0;
        flags_o[FLG_EQ]   = eq;
        flags_o[FLG_NEQ]  = ~eq;
        flags_o[FLG_CEQ]  = eq;
        flags_o[FLG_CNEQ] = ~eq;
        flags_o[FLG_LT]   = lt;
        flags_o[FLG_GT]   = ~lt & ~eq;
        flags_o[FLG_LTE]  = lt | eq;
        flags_o[FLG_GTE]  = ~lt;
    end

endmodule
`default_nettype wire

// File: rtl/rel_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rel_cmp_arbiter
// Purpose : Round-robin sharing of one relational comparator among N_REQ clients.
// Revision: 1.0 - initial release
// ============================================================================
module rel_cmp_arbiter
    import rel_cmp_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    input  logic [N_REQ*3-1:0]     op_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_result,
    output logic [N_FLAGS-1:0]     rsp_flags,
    output logic                   busy
);

    state_e               state_q;
    logic [ID_W-1:0]      last_id_q;
    logic [ID_W-1:0]      id_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2:0]           op_q;
    logic [N_REQ-1:0]     gnt_q;
    logic                 rsp_valid_q;
    logic [ID_W-1:0]      rsp_id_q;
    logic                 rsp_result_q;
    logic [N_FLAGS-1:0]   rsp_flags_q;
    logic                 busy_q;

    logic [WIDTH-1:0]     a_arr  [N_REQ];
    logic [WIDTH-1:0]     b_arr  [N_REQ];
    logic [2:0]           op_arr [N_REQ];
    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    logic [ID_W-1:0]      cand;
    logic [N_FLAGS-1:0]   flags;

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
            assign a_arr[i]  = a_in[i*WIDTH +: WIDTH];
            assign b_arr[i]  = b_in[i*WIDTH +: WIDTH];
            assign op_arr[i] = op_in[i*3 +: 3];
        end
    endgenerate

    // Search starts one past the last grant, so the last winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_id_q) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    rel_cmp_unit #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp (
        .a_i     (a_q),
        .b_i     (b_q),
        .flags_o (flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_id_q    <= ID_W'(N_REQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= 1'b0;
            rsp_flags_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        a_q     <= a_arr[win_id];
                        b_q     <= b_arr[win_id];
                        op_q    <= op_arr[win_id];
                        id_q    <= win_id;
                        gnt_q   <= N_REQ'(1) << win_id;
                        busy_q  <= 1'b1;
                        state_q <= S_CAP;
                    end
                end
                S_CAP: begin
                    gnt_q     <= '0;
                    last_id_q <= id_q;
                    state_q   <= S_CMP;
                end
                S_CMP: begin
                    rsp_flags_q  <= flags;
                    rsp_result_q <= rel_select(flags, op_q);
                    rsp_id_q     <= id_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rel_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rel_cmp_arbiter
// Purpose : Self-checking bench for rel_cmp_arbiter (unsigned and signed builds).
// Revision: 1.0 - initial release
// ============================================================================
module tb_rel_cmp_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N*3-1:0] op_in;
    logic           rsp_ready;

    logic [N-1:0]   gnt_u, gnt_s;
    logic           rv_u, rv_s;
    logic [1:0]     id_u, id_s;
    logic           res_u, res_s;
    logic [7:0]     fl_u, fl_s;
    logic           busy_u, busy_s;

    int checks = 0;
    int errors = 0;
    int last_model = N - 1;

    always #5 clk = ~clk;

    rel_cmp_arbiter #(.N_REQ(N), .WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .gnt(gnt_u), .rsp_valid(rv_u), .rsp_ready(rsp_ready), .rsp_id(id_u),
        .rsp_result(res_u), .rsp_flags(fl_u), .busy(busy_u)
    );

    rel_cmp_arbiter #(.N_REQ(N), .WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .gnt(gnt_s), .rsp_valid(rv_s), .rsp_ready(rsp_ready), .rsp_id(id_s),
        .rsp_result(res_s), .rsp_flags(fl_s), .busy(busy_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Flags straight from integer ordering of the operands.
    function automatic logic [7:0] model_flags(input logic [3:0] a, input logic [3:0] b, input bit sgn);
        int av, bv;
        av = (sgn && a[3]) ? int'(a) - 16 : int'(a);
        bv = (sgn && b[3]) ? int'(b) - 16 : int'(b);
        return {av >= bv, av <= bv, av > bv, av < bv, av != bv, av == bv, av != bv, av == bv};
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt_u), 32'd0);
        chk({tag, "_valid"}, 32'(rv_u), 32'd0);
        chk({tag, "_valid_s"}, 32'(rv_s), 32'd0);
        chk({tag, "_id"}, 32'(id_u), 32'd0);
        chk({tag, "_result"}, 32'(res_u), 32'd0);
        chk({tag, "_flags"}, 32'(fl_u), 32'd0);
        chk({tag, "_busy"}, 32'(busy_u), 32'd0);
    endtask

    // Entered #1 after a posedge with the DUT idle; leaves in the same alignment.
    task automatic run_op(input logic [N-1:0] r, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                          input logic [N*3-1:0] op, input int exp_id,
                          input logic [7:0] fu, input logic ru, input logic [7:0] fs, input logic rs,
                          input int stall, input bit drop);
        req = r; a_in = a; b_in = b; op_in = op; rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("gnt", 32'(gnt_u), 32'd1 << exp_id);
        chk("busy", 32'(busy_u), 32'd1);
        chk("valid_early", 32'(rv_u), 32'd0);
        if (drop) req = '0;
        @(posedge clk); #1;
        chk("gnt_pulse", 32'(gnt_u), 32'd0);
        @(posedge clk); #1;
        chk("rsp_valid", 32'(rv_u), 32'd1);
        chk("rsp_id", 32'(id_u), 32'(exp_id));
        chk("rsp_flags", 32'(fl_u), 32'(fu));
        chk("rsp_result", 32'(res_u), 32'(ru));
        chk("rsp_flags_s", 32'(fl_s), 32'(fs));
        chk("rsp_result_s", 32'(res_s), 32'(rs));
        rsp_ready = (stall == 0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(rv_u), 32'd1);
            chk("stall_id", 32'(id_u), 32'(exp_id));
            chk("stall_flags", 32'(fl_u), 32'(fu));
            chk("stall_result", 32'(res_u), 32'(ru));
            chk("stall_gnt", 32'(gnt_u), 32'd0);
            if (s == stall - 1) rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("valid_done", 32'(rv_u), 32'd0);
        chk("busy_done", 32'(busy_u), 32'd0);
        last_model = exp_id;
    endtask

    task automatic run_model(input logic [N-1:0] r, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                             input logic [N*3-1:0] op, input int stall, input bit drop);
        int         id;
        logic [7:0] fu, fs;
        logic [2:0] oc;
        id = pick(r, last_model);
        fu = model_flags(a[id*W +: W], b[id*W +: W], 1'b0);
        fs = model_flags(a[id*W +: W], b[id*W +: W], 1'b1);
        oc = op[id*3 +: 3];
        run_op(r, a, b, op, id, fu, fu[oc], fs, fs[oc], stall, drop);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        last_model = N - 1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [N-1:0]   r;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        logic [N*3-1:0] op;
        int             id;
        logic [7:0]     fu;
        logic           ru;
        logic [7:0]     fs;
        logic           rs;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{4'b0001, 16'h000D, 16'h0005, 12'h005, 0, 8'hAA, 1'b1, 8'h5A, 1'b0};
        tbl[1] = '{4'b0100, 16'h0300, 16'h0300, 12'h180, 2, 8'hC5, 1'b1, 8'hC5, 1'b1};
        tbl[2] = '{4'b0001, 16'h0008, 16'h0007, 12'h004, 0, 8'hAA, 1'b0, 8'h5A, 1'b1};
        tbl[3] = '{4'b1111, 16'h0000, 16'h00F0, 12'h020, 1, 8'h5A, 1'b1, 8'hAA, 1'b0};
        tbl[4] = '{4'b1001, 16'h7000, 16'h7000, 12'h600, 3, 8'hC5, 1'b0, 8'hC5, 1'b0};
        tbl[5] = '{4'b0011, 16'h0002, 16'h0009, 12'h007, 0, 8'h5A, 1'b0, 8'hAA, 1'b1};

        rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; op_in = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_req_busy", 32'(busy_u), 32'd0);

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].id,
                   tbl[i].fu, tbl[i].ru, tbl[i].fs, tbl[i].rs, 0, 1'b1);

        // Fairness from a fresh reset: all four held for eight operations.
        reset_pulse();
        for (int k = 0; k < 8; k++) begin
            logic [N*W-1:0] fa, fb;
            logic [N*3-1:0] fo;
            int             id;
            logic [7:0]     fu, fs;
            fa = N*W'($urandom); fb = N*W'($urandom); fo = N*3'($urandom);
            id = k % N;
            fu = model_flags(fa[id*W +: W], fb[id*W +: W], 1'b0);
            fs = model_flags(fa[id*W +: W], fb[id*W +: W], 1'b1);
            run_op(4'b1111, fa, fb, fo, id, fu, fu[fo[id*3 +: 3]], fs, fs[fo[id*3 +: 3]], 0, 1'b0);
        end

        // Backpressure with every requester still asserting.
        run_model(4'b1111, 16'h5A3C, 16'hC3A5, 12'hFAC, 5, 1'b0);

        // Reset during CMP aborts the operation; requester 0 wins afterwards.
        req = 4'b0110; a_in = 16'h1234; b_in = 16'h4321; op_in = 12'h0A5; rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("abort_gnt", 32'(gnt_u), 32'd1 << pick(4'b0110, last_model));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); #1;
        chk("abort_no_valid", 32'(rv_u), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_model = N - 1;
        run_op(4'b1111, 16'h0003, 16'h0003, 12'h000, 0, 8'hC5, 1'b1, 8'hC5, 1'b1, 0, 1'b1);

        for (int k = 0; k < 40; k++)
            run_model(N'($urandom_range(1, 15)), N*W'($urandom), N*W'($urandom), N*3'($urandom),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/rel_cmp_arbiter.md
# rel_cmp_arbiter

Round-robin scheduler that shares one relational-compare datapath among `N_REQ` requesters. Each requester submits an operand pair and a 3-bit relation code. The block grants one requester at a time, registers its operands, evaluates all eight relations (eq, neq, ceq, cneq, lt, gt, lte, gte) in the shared compare unit, and returns the selected result plus the full flag vector over a valid/ready response handshake. It sits between multiple operator clients and the single comparator so the comparator is never duplicated.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 4: operand width in bits.
- `SIGNED`, 0: 1 = lt/gt/lte/gte use two's-complement ordering; 0 = unsigned.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronous to `clk`.
- `req`, in, `N_REQ`: per-requester request level.
- `a_in`, in, `N_REQ*WIDTH`: operand A. Requester i uses `[i*WIDTH +: WIDTH]`.
- `b_in`, in, `N_REQ*WIDTH`: operand B, same packing as `a_in`.
- `op_in`, in, `N_REQ*3`: relation code. 0 eq, 1 neq, 2 ceq, 3 cneq, 4 lt, 5 gt, 6 lte, 7 gte.
- `gnt`, out, `N_REQ`: one-hot grant, single-cycle pulse.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: response accepted.
- `rsp_id`, out, `$clog2(N_REQ)`: index of the granted requester.
- `rsp_result`, out, 1: the flag selected by the captured op code.
- `rsp_flags`, out, 8: {gte,lte,gt,lt,cneq,ceq,neq,eq}, with eq in bit 0.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states are IDLE, CAP, CMP, RESP.
- IDLE: if `req` is nonzero, choose the winner round-robin. The search starts at `last_id+1` modulo `N_REQ`, where `last_id` is the most recently granted requester. Capture the winner's a, b, op and id, then go to CAP. If `req` is zero, stay in IDLE.
- CAP: drive `gnt` one-hot for the captured id for this one cycle, update `last_id`, go to CMP.
- CMP: the compare unit evaluates all eight relations on the captured operands. Register `rsp_flags`, `rsp_result` and `rsp_id`, then go to RESP.
- RESP: hold `rsp_valid=1` with stable outputs. When `rsp_ready=1`, return to IDLE. If `rsp_ready=0`, stay in RESP.
- Requester contract: hold `req`, operands and op stable until `gnt` is seen, then drop `req` or present a new operation. Requests that arrive while the FSM is not in IDLE are ignored until it returns to IDLE.
- Synthesizable ceq/cneq evaluate identically to eq/neq. Only simulation models with x/z values distinguish them.
- Flag invariants: neq = ~eq; lte = lt|eq; gte = gt|eq. Exactly one of lt, eq, gt is 1.

## Timing
- A request sampled in IDLE at edge n produces `gnt` high during cycle n+1, `rsp_valid` high from cycle n+3, and the earliest return to IDLE at n+4.
- Peak throughput is one operation per 4 cycles. Each `rsp_ready` stall adds one cycle.
- Reset values: state IDLE, `gnt`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_flags`=0, `busy`=0, `last_id`=`N_REQ-1` so that requester 0 wins first.
- Reset asserted mid-operation aborts the operation immediately. No response is produced and requesters must re-request.
- Wrap-around: when `last_id`=`N_REQ-1`, the search starts at 0.
- `rsp_ready` high outside RESP has no effect.

## Structure
- Shared package `rel_cmp_pkg` holds:
  - relation code localparams (`REL_EQ`..`REL_GTE`);
  - state encoding localparams;
  - flag bit-position localparams.
- Sub-module `rel_cmp_unit`: purely combinational; inputs a, b and `SIGNED`; output is the 8-bit flag vector.
- The FSM, arbiter and capture registers live in the top module.

## Test plan
- Reset then a single request: `req`=0001, a=1101, b=0101, op=5 (gt). Expect `gnt`=0001 one cycle later, then `rsp_valid` with `rsp_result`=1, `rsp_flags`=8'b1010_1010, `rsp_id`=0.
- Equal operands: a=b=0011 on requester 2, op=6. Expect `rsp_flags`=8'b1100_0101 and `rsp_result`=1.
- Fairness: all four requesters held active for 8 operations. Expect grant order 0,1,2,3,0,1,2,3 and each `rsp_id` matching its grant.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP. Expect `rsp_valid` and all response fields stable, with no new `gnt` issued.
- Signed build (`SIGNED`=1): a=1000 (-8), b=0111, op=4. Expect `rsp_result`=1. With `SIGNED`=0, expect 0.
- Reset pulse during CMP: expect all outputs at reset values at once and no `rsp_valid`. The next request from requester 0 is granted first.
